// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - control state encodings, opcode constants and field positions for fetch_unit
package fetch_unit_pkg;

    // Control state encodings shared with the sequencer; codes 5..7 are undefined.
    typedef enum logic [2:0] {
        CS_IDLE   = 3'd0,
        CS_FETCHA = 3'd1,
        CS_FETCHB = 3'd2,
        CS_EXECA  = 3'd3,
        CS_EXECB  = 3'd4
    } cs_e;

    localparam int CS_W  = 3;
    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_NOP = 5'h00;
    localparam logic [OPC_W-1:0] OP_LD  = 5'h01;
    localparam logic [OPC_W-1:0] OP_ST  = 5'h02;
    localparam logic [OPC_W-1:0] OP_JMP = 5'h03;
    localparam logic [OPC_W-1:0] OP_BZ  = 5'h04;
    localparam logic [OPC_W-1:0] OP_HLT = 5'h1F;

    // Opcode occupies the top OPC_W bits of the instruction word.
    function automatic int opc_msb(input int instr_w);
        return instr_w - 1;
    endfunction

endpackage

// File: rtl/fetch_unit_decode.sv
// rtl/fetch_unit_decode.sv - instr_decode: combinational opcode decode (branch decode under FETCH_BRANCH_EN)
module instr_decode
    import fetch_unit_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic [CS_W-1:0]  cs,
    input  logic             zero,
    output logic             halt,
    output logic             cont,
    output logic             branch_taken
);

    // Decode is only meaningful in EXECA; every other state forces all flags low.
    always_comb begin
        halt         = 1'b0;
        cont         = 1'b0;
        branch_taken = 1'b0;
        if (cs == CS_EXECA) begin
            case (opcode)
                OP_HLT:       halt = 1'b1;
                OP_LD, OP_ST: cont = 1'b1;
`ifdef FETCH_BRANCH_EN
                OP_JMP:       branch_taken = 1'b1;
                OP_BZ:        branch_taken = zero;
`endif
                default:      ;
            endcase
        end
    end

`ifndef FETCH_BRANCH_EN
    // Without branches the zero flag has no consumer.
    logic unused_zero;
    assign unused_zero = zero;
`endif

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/IR fetch stage; branch redirect enabled by FETCH_BRANCH_EN
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CS_W-1:0]    cs,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               zero,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_rd,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic               halt,
    output logic               cont,
    output logic               branch_taken
);

    localparam int OPC_MSB = opc_msb(INSTR_W);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    instr_decode u_decode (
        .opcode       (ir_q[OPC_MSB -: OPC_W]),
        .cs           (cs),
        .zero         (zero),
        .halt         (halt),
        .cont         (cont),
        .branch_taken (branch_taken)
    );

    // Next PC/IR: capture and increment in FETCHB, redirect at the end of EXECA, hold otherwise.
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        case (cs)
            CS_FETCHB: begin
                ir_d = imem_data;
                pc_d = pc_q + ADDR_W'(1);
            end
            CS_EXECA: begin
                if (branch_taken) begin
                    pc_d = ir_q[ADDR_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // PC/IR registers; reset overrides any control state, discarding a word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= ADDR_W'(RESET_PC);
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign pc        = pc_q;
    assign ir        = ir_q;
    assign imem_addr = pc_q;
    assign imem_rd   = (cs == CS_FETCHA);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: directed plan plus randomized run against a reference model
module tb_fetch_unit;

    localparam int IDLE   = 0;
    localparam int FETCHA = 1;
    localparam int FETCHB = 2;
    localparam int EXECA  = 3;
    localparam int EXECB  = 4;

`ifdef FETCH_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i;
    logic [2:0]  cs_i;
    logic [15:0] imem_data_i;
    logic        zero_i;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        halt;
    logic        cont;
    logic        branch_taken;

    int checks   = 0;
    int failures = 0;

    int m_pc = 0;
    int m_ir = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(0)) dut (
        .clk          (clk),
        .reset        (reset_i),
        .cs           (cs_i),
        .imem_data    (imem_data_i),
        .zero         (zero_i),
        .imem_addr    (imem_addr),
        .imem_rd      (imem_rd),
        .pc           (pc),
        .ir           (ir),
        .halt         (halt),
        .cont         (cont),
        .branch_taken (branch_taken)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_taken(input int c, input bit z);
        int op;
        op = m_ir / 2048;
        if (!BR_EN || c != EXECA) return 1'b0;
        return (op == 3) || (op == 4 && z);
    endfunction

    // One clock cycle: apply inputs, check combinational outputs (zero may change
    // mid-cycle from z0 to z1), take the edge, then check the registers.
    task automatic step(input int c, input int d, input bit z0, input bit z1, input bit r);
        int  op;
        bit  tk;
        cs_i        = 3'(c);
        imem_data_i = 16'(d);
        zero_i      = z0;
        reset_i     = r;
        #1;
        op = m_ir / 2048;
        chk("imem_rd",   {31'd0, imem_rd},   {31'd0, c == FETCHA});
        chk("imem_addr", {24'd0, imem_addr}, 32'(m_pc));
        chk("halt",      {31'd0, halt},      {31'd0, c == EXECA && op == 31});
        chk("cont",      {31'd0, cont},      {31'd0, c == EXECA && (op == 1 || op == 2)});
        chk("bt_early",  {31'd0, branch_taken}, {31'd0, model_taken(c, z0)});
        zero_i = z1;
        #1;
        tk = model_taken(c, z1);
        chk("bt_late",   {31'd0, branch_taken}, {31'd0, tk});
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 0;
            m_ir = 0;
        end else if (c == FETCHB) begin
            m_ir = d % 65536;
            m_pc = (m_pc + 1) % 256;
        end else if (tk) begin
            m_pc = m_ir % 256;
        end
        chk("pc", {24'd0, pc}, 32'(m_pc));
        chk("ir", {16'd0, ir}, 32'(m_ir));
    endtask

    task automatic fetch(input int word, input bit z);
        step(FETCHA, 0, 0, 0, 0);
        step(FETCHB, word, 0, 0, 0);
        step(EXECA, 0, z, z, 0);
    endtask

    initial begin
        int old_pc;
        reset_i     = 1'b1;
        cs_i        = 3'(IDLE);
        imem_data_i = '0;
        zero_i      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        m_pc = 0;
        m_ir = 0;

        // Reset state
        step(IDLE, 0, 0, 0, 1);
        chk("rst_pc", {24'd0, pc}, 32'h0);
        chk("rst_ir", {16'd0, ir}, 32'h0);
        chk("rst_rd", {31'd0, imem_rd}, 32'h0);

        // LD fetch
        step(FETCHA, 0, 0, 0, 0);
        step(FETCHB, 16'h0800, 0, 0, 0);
        chk("ld_ir", {16'd0, ir}, 32'h0800);
        chk("ld_pc", {24'd0, pc}, 32'h1);
        cs_i = 3'(EXECA);
        #1;
        chk("ld_cont", {31'd0, cont}, 32'h1);
        chk("ld_halt", {31'd0, halt}, 32'h0);
        step(EXECA, 0, 0, 0, 0);
        step(EXECB, 0, 0, 0, 0);

        // Wrap via JMP FF then NOP
        fetch(16'h18FF, 0);
        if (BR_EN) chk("jmp_pc", {24'd0, pc}, 32'hFF);
        fetch(16'h0000, 0);
        if (BR_EN) chk("wrap_pc", {24'd0, pc}, 32'h00);

        // BZ taken with zero rising mid-cycle, then not taken
        step(FETCHA, 0, 0, 0, 0);
        step(FETCHB, 16'h2042, 0, 0, 0);
        step(EXECA, 0, 0, 1, 0);
        if (BR_EN) chk("bz_taken_pc", {24'd0, pc}, 32'h42);
        old_pc = m_pc;
        step(FETCHA, 0, 0, 0, 0);
        step(FETCHB, 16'h2042, 0, 0, 0);
        step(EXECA, 0, 0, 0, 0);
        chk("bz_nt_pc", {24'd0, pc}, 32'((old_pc + 1) % 256));

        // HLT fetched from address 5
        step(IDLE, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) fetch(16'h0000, 0);
        chk("pre_hlt_pc", {24'd0, pc}, 32'h5);
        step(FETCHA, 0, 0, 0, 0);
        step(FETCHB, 16'hF800, 0, 0, 0);
        cs_i = 3'(EXECA);
        #1;
        chk("hlt_halt", {31'd0, halt}, 32'h1);
        chk("hlt_cont", {31'd0, cont}, 32'h0);
        step(EXECA, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(IDLE, 0, 0, 0, 0);
        chk("hlt_idle_pc", {24'd0, pc}, 32'h6);

        // Reset during FETCHB discards the word
        step(FETCHA, 0, 0, 0, 0);
        step(FETCHB, 16'h1234, 0, 0, 1);
        chk("rfb_ir", {16'd0, ir}, 32'h0);
        chk("rfb_pc", {24'd0, pc}, 32'h0);
        step(IDLE, 0, 0, 0, 0);

        // JMP 0x10: redirect only when branches are built in
        old_pc = m_pc;
        fetch(16'h1810, 1);
        chk("jmp10_pc", {24'd0, pc}, BR_EN ? 32'h10 : 32'((old_pc + 1) % 256));

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            int c;
            int d;
            c = $urandom_range(0, 7);
            d = $urandom_range(0, 65535);
            if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 4) * 2048) + (d % 2048);
            step(c, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 49) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and instruction-register stage driven by the processor's control state `cs`. Addresses instruction memory during FETCHA, captures the returned word during FETCHB, and decodes the captured instruction during EXECA. Decoding produces the `halt` and `cont` inputs that the control state machine samples. It sits directly downstream of the state sequencer and upstream of the datapath, which consumes `ir`.

## Interface
- `ADDR_W`, default 8: PC and instruction-memory address width.
- `INSTR_W`, default 16: instruction width. The opcode is `ir[INSTR_W-1:INSTR_W-5]` and the target field is `ir[ADDR_W-1:0]`.
- `RESET_PC`, default 0: PC value after reset.

Ports:
- `clk` input 1: the single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `cs` input 3: current control state, using the encodings from `define.v` (IDLE, FETCHA, FETCHB, EXECA, EXECB).
- `imem_data` input INSTR_W: instruction memory read data. The memory is synchronous with 1-cycle read latency.
- `zero` input 1: datapath zero flag, used by BZ.
- `imem_addr` output ADDR_W: instruction memory address.
- `imem_rd` output 1: instruction memory read enable.
- `pc` output ADDR_W: registered program counter.
- `ir` output INSTR_W: registered instruction register.
- `halt` output 1: current instruction is HLT. Combinational, valid in EXECA only.
- `cont` output 1: current instruction needs EXECB. Combinational, valid in EXECA only.
- `branch_taken` output 1: a PC redirect happens at the end of this EXECA cycle.

## Operation
- Opcodes are defined in `define.v`:
  - `OP_NOP` = 5'h00
  - `OP_LD` = 5'h01
  - `OP_ST` = 5'h02
  - `OP_JMP` = 5'h03
  - `OP_BZ` = 5'h04
  - `OP_HLT` = 5'h1F
- Unlisted opcodes decode as NOP.
- `imem_addr` = `pc` at all times. `imem_rd` = 1 only while `cs`==FETCHA.
- When `cs`==FETCHB at the rising edge: `ir` <= `imem_data` and `pc` <= `pc`+1, both modulo 2^ADDR_W. PC 2^ADDR_W−1 wraps to 0.
- When `cs`==EXECA:
  - `halt` = 1 for HLT.
  - `cont` = 1 for LD or ST.
  - `branch_taken` = 1 for JMP, or for BZ with `zero`=1.
  - At the edge, if `branch_taken`, then `pc` <= `ir[ADDR_W-1:0]`.
- In any other state, `halt`, `cont` and `branch_taken` are 0.
- EXECB, IDLE, and undefined `cs` codes: `pc` and `ir` hold.
- PC and IR are retained across IDLE, so a later run resumes at the current `pc`.
- HLT does not alter `pc`. After a halt, `pc` points to the word following HLT.

## Timing
- Reset values: `pc`=RESET_PC, `ir`=0 (NOP), `imem_rd`=0, `halt`=0, `cont`=0, `branch_taken`=0.
- `imem_addr` = RESET_PC from the first cycle after reset.
- Reset takes priority over any `cs` value. Reset during FETCHB discards the incoming word.
- Fetch latency: the address is presented in FETCHA, data returns in FETCHB, and `ir` is valid from the first EXECA cycle.
- Instruction cadence:
  - 3 cycles: FETCHA, FETCHB, EXECA.
  - 4 cycles with EXECB.
  - Branch target is fetched in the very next FETCHA.
- `halt`, `cont` and `branch_taken` are combinational from `ir`, `cs` and `zero`. No registered delay is allowed, because the sequencer samples them on the same edge.
- A BZ with a `zero` change mid-cycle uses the value at the EXECA edge.

## Configuration
- `FETCH_BRANCH_EN` defined:
  - JMP and BZ decode and redirect as above.
  - `branch_taken` is live.
- `FETCH_BRANCH_EN` not defined:
  - JMP and BZ decode as NOP.
  - `branch_taken` is tied to 0.
  - `zero` is ignored.
  - PC is modified only by reset and FETCHB increment.

## Structure
- Shared `define.v` holds:
  - the state encodings (shared with the sequencer);
  - the `OP_*` opcode constants;
  - the opcode field position macros.
- One sub-module, `instr_decode`: purely combinational. It maps opcode, `cs` and `zero` to `halt`, `cont` and `branch_taken`. PC/IR registers remain in `fetch_unit`.

## Test plan
- Reset, then drive cs=FETCHA: `imem_rd`=1, `imem_addr`=0. Drive FETCHB with imem_data=16'h0800 (LD): `ir`=16'h0800, `pc`=1. Then EXECA: `cont`=1, `halt`=0.
- Wrap: preload `pc`=8'hFF via JMP 16'h18FF. Fetch a NOP: `pc` becomes 8'h00.
- BZ 16'h2042 in EXECA:
  - with zero=1: `branch_taken`=1, next `pc`=8'h42;
  - with zero=0: `pc` unchanged (prior +1 only).
- HLT 16'hF800 fetched from address 5: EXECA gives `halt`=1, `cont`=0. After that, `pc`=6 and holds while cs=IDLE.
- Assert `reset` during FETCHB with imem_data=16'h1234: next cycle `ir`=0, `pc`=RESET_PC, all outputs 0.
- Build without `FETCH_BRANCH_EN`: JMP 16'h1810 gives `branch_taken`=0, `cont`=0, `halt`=0, and `pc` increments normally.
